// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W writer tracking, stall generation and forward selects for a 5-stage MIPS pipeline
module hazard_scoreboard #(
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [4:0]        rs_D,
   input  logic [4:0]        rt_D,
   input  logic [TNEW_W-1:0] tuse_rs_D,
   input  logic [TNEW_W-1:0] tuse_rt_D,
   input  logic [4:0]        a3_D,
   input  logic              wen_D,
   input  logic [TNEW_W-1:0] tnew_D,
   input  logic              md_D,
   input  logic              md_busy,
   output logic              stall,
   output logic [2:0]        FRSD,
   output logic [2:0]        FRTD,
   output logic [1:0]        FRSE,
   output logic [1:0]        FRTE
);
   logic              e_wen_q, m_wen_q, w_wen_q, e_wen_d, m_wen_d, w_wen_d;
   logic [4:0]        e_a3_q, m_a3_q, w_a3_q, e_a3_d, m_a3_d, w_a3_d;
   logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, w_tnew_q, e_tnew_d, m_tnew_d, w_tnew_d;
   logic [4:0]        e_rs_q, e_rt_q, e_rs_d, e_rt_d;
   logic              e_wr, m_wr, w_wr;
   logic [3:0]        rs_f, rt_f;

   assign e_wr = e_wen_q && e_a3_q != '0;
   assign m_wr = m_wen_q && m_a3_q != '0;
   assign w_wr = w_wen_q && w_a3_q != '0;

   // Youngest matching writer decides {stall, D select}; tuse of all ones means the source is unused
   function automatic logic [3:0] dsrc(input logic [4:0] r, input logic [TNEW_W-1:0] t,
                                       input logic ew, input logic mw, input logic ww,
                                       input logic [4:0] ea, input logic [4:0] ma, input logic [4:0] wa,
                                       input logic [TNEW_W-1:0] et, input logic [TNEW_W-1:0] mt);
      if (t == '1) return 4'd0;
      if (ew && ea == r) return {et > t, et == '0 ? 3'd3 : 3'd0};
      if (mw && ma == r) return {mt > t, mt == '0 ? 3'd2 : 3'd0};
      if (ww && wa == r) return 4'd1;
      return 4'd0;
   endfunction

   // E-stage select: a ready M result beats W, otherwise keep the latched operand
   function automatic logic [1:0] esrc(input logic [4:0] r, input logic mw, input logic [4:0] ma,
                                       input logic [TNEW_W-1:0] mt, input logic ww, input logic [4:0] wa);
      return (mw && ma == r && mt == '0) ? 2'd2 : (ww && wa == r) ? 2'd1 : 2'd0;
   endfunction

   // Hazard detection and forward selects, purely from slot state and D inputs
   always_comb begin
      rs_f  = dsrc(rs_D, tuse_rs_D, e_wr, m_wr, w_wr, e_a3_q, m_a3_q, w_a3_q, e_tnew_q, m_tnew_q);
      rt_f  = dsrc(rt_D, tuse_rt_D, e_wr, m_wr, w_wr, e_a3_q, m_a3_q, w_a3_q, e_tnew_q, m_tnew_q);
      stall = rs_f[3] | rt_f[3] | (md_D & md_busy);
      FRSD  = stall ? 3'd0 : rs_f[2:0];
      FRTD  = stall ? 3'd0 : rt_f[2:0];
      FRSE  = esrc(e_rs_q, m_wr, m_a3_q, m_tnew_q, w_wr, w_a3_q);
      FRTE  = esrc(e_rt_q, m_wr, m_a3_q, m_tnew_q, w_wr, w_a3_q);
   end

   // Slot advance: D enters E (bubble on stall), tnew counts down saturating at zero
   always_comb begin
      e_wen_d  = stall ? 1'b0 : wen_D;
      e_a3_d   = stall ? 5'd0 : a3_D;
      e_tnew_d = stall ? '0 : tnew_D;
      e_rs_d   = stall ? 5'd0 : rs_D;
      e_rt_d   = stall ? 5'd0 : rt_D;
      m_wen_d  = e_wen_q;
      m_a3_d   = e_a3_q;
      m_tnew_d = e_tnew_q == '0 ? '0 : e_tnew_q - 1'b1;
      w_wen_d  = m_wen_q;
      w_a3_d   = m_a3_q;
      w_tnew_d = m_tnew_q == '0 ? '0 : m_tnew_q - 1'b1;
   end

   // Slot registers; clear turns every slot into a bubble
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         e_wen_q  <= 1'b0;
         e_a3_q   <= '0;
         e_tnew_q <= '0;
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         m_wen_q  <= 1'b0;
         m_a3_q   <= '0;
         m_tnew_q <= '0;
         w_wen_q  <= 1'b0;
         w_a3_q   <= '0;
         w_tnew_q <= '0;
      end else begin
         e_wen_q  <= e_wen_d;
         e_a3_q   <= e_a3_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         m_wen_q  <= m_wen_d;
         m_a3_q   <= m_a3_d;
         m_tnew_q <= m_tnew_d;
         w_wen_q  <= w_wen_d;
         w_a3_q   <= w_a3_d;
         w_tnew_q <= w_tnew_d;
      end
   end
endmodule
